// File: rtl/pc_seq_if.sv
// Fetch-stage sequencer bundle: redirect/stall controls toward the sequencer, PC and RAS status back.
// The master side drives the controls; the sequencer connects through the slave modport.
interface pc_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             stall;
  logic             jump;
  logic [WIDTH-1:0] jump_target;
  logic             branch_taken;
  logic [WIDTH-1:0] branch_target;
  logic             call;
  logic             ret;
  logic [WIDTH-1:0] pc_out;
  logic [WIDTH-1:0] pc_plus_out;
  logic             pc_valid;
  logic             flush;
  logic             ras_empty;
  logic             ras_full;

  modport master (
    output stall, jump, jump_target, branch_taken, branch_target, call, ret,
    input  pc_out, pc_plus_out, pc_valid, flush, ras_empty, ras_full
  );

  modport slave (
    input  stall, jump, jump_target, branch_taken, branch_target, call, ret,
    output pc_out, pc_plus_out, pc_valid, flush, ras_empty, ras_full
  );
endinterface

// File: rtl/pc_sequencer.sv
// Registered fetch PC sequencer: BOOT/RUN/REDIR control with branch > jump > ret > stall > sequential.
// Define PC_RAS_EN to add the circular return-address stack serving call/ret.
module pc_sequencer #(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      STEP      = 1,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  parameter int unsigned      RAS_DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  pc_seq_if.slave  bus
);

  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, REDIR = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pc_plus;
  logic             valid_q, valid_d;
  logic             flush_q, flush_d;
  logic             redir;
  logic [WIDTH-1:0] redir_pc;
  logic             push, pop, ret_ok;
  logic [WIDTH-1:0] ras_top;

  // Carry out of the increment is dropped on purpose: the PC wraps silently.
  assign pc_plus = pc_q + WIDTH'(STEP);

`ifdef PC_RAS_EN
  localparam int unsigned PW = $clog2(RAS_DEPTH);

  logic [PW-1:0]    top_q, top_d;
  logic [PW:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];

  assign ras_top = ras_mem[top_q];
  assign ret_ok  = bus.ret && (cnt_q != '0);

  // top_q points at the newest entry; a push when full simply laps the oldest slot.
  always_comb begin
    top_d = top_q;
    cnt_d = cnt_q;
    if (push) begin
      top_d = top_q + 1'b1;
      if (cnt_q != (PW+1)'(RAS_DEPTH)) cnt_d = cnt_q + 1'b1;
    end else if (pop) begin
      top_d = top_q - 1'b1;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_q <= '0;
      cnt_q <= '0;
    end else begin
      top_q <= top_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) ras_mem[top_d] <= pc_plus;
  end

  assign bus.ras_empty = (cnt_q == '0);
  assign bus.ras_full  = (cnt_q == (PW+1)'(RAS_DEPTH));
`else
  localparam logic [31:0] RAS_D = RAS_DEPTH;
  logic unused_ras;

  assign ret_ok        = 1'b0;
  assign ras_top       = '0;
  assign bus.ras_empty = 1'b1;
  assign bus.ras_full  = 1'b0;
  assign unused_ras    = ^{bus.call, bus.ret, push, pop, RAS_D[0]};
`endif

  // Redirects bypass stall; BOOT ignores all controls for its single cycle.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    valid_d  = valid_q;
    flush_d  = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    redir    = 1'b0;
    redir_pc = pc_q;
    if (state_q == BOOT) begin
      state_d = RUN;
      valid_d = 1'b1;
    end else begin
      if (bus.branch_taken) begin
        redir    = 1'b1;
        redir_pc = bus.branch_target;
      end else if (bus.jump) begin
        redir    = 1'b1;
        redir_pc = bus.jump_target;
        push     = bus.call;
      end else if (ret_ok) begin
        redir    = 1'b1;
        redir_pc = ras_top;
        pop      = 1'b1;
      end
      if (redir) begin
        pc_d    = redir_pc;
        valid_d = 1'b0;
        flush_d = 1'b1;
        state_d = REDIR;
      end else if (!bus.stall) begin
        pc_d    = pc_plus;
        valid_d = 1'b1;
        state_d = RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      flush_q <= flush_d;
    end
  end

  assign bus.pc_out      = pc_q;
  assign bus.pc_plus_out = pc_plus;
  assign bus.pc_valid    = valid_q;
  assign bus.flush       = flush_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer (WIDTH=8, STEP=1, RESET_PC=0, RAS_DEPTH=4); RAS scenarios run when PC_RAS_EN is defined.
module tb_pc_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: PC value, valid/flush flags, boot flag and the return stack as a queue.
  logic [7:0] m_pc;
  logic       m_valid, m_flush, m_boot;
  logic [7:0] m_ras[$];

  pc_seq_if #(.WIDTH(8)) bus ();

  pc_sequencer #(.WIDTH(8), .STEP(1), .RESET_PC(8'h00), .RAS_DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    bus.stall = 0; bus.jump = 0; bus.jump_target = '0; bus.branch_taken = 0;
    bus.branch_target = '0; bus.call = 0; bus.ret = 0;
  endtask

  task automatic model_reset();
    m_pc = 8'h00; m_valid = 0; m_flush = 0; m_boot = 1;
    m_ras.delete();
  endtask

  task automatic model_step();
    logic       redirect;
    logic [7:0] tgt;
    redirect = 0;
    tgt = '0;
    if (m_boot) begin
      m_boot = 0; m_valid = 1; m_flush = 0;
    end else begin
      if (bus.branch_taken) begin
        redirect = 1; tgt = bus.branch_target;
      end else if (bus.jump) begin
        redirect = 1; tgt = bus.jump_target;
`ifdef PC_RAS_EN
        if (bus.call) begin
          if (m_ras.size() == 4) void'(m_ras.pop_front());
          m_ras.push_back(m_pc + 8'd1);
        end
`endif
      end
`ifdef PC_RAS_EN
      else if (bus.ret && m_ras.size() > 0) begin
        redirect = 1; tgt = m_ras.pop_back();
      end
`endif
      if (redirect) begin
        m_pc = tgt; m_valid = 0; m_flush = 1;
      end else if (bus.stall) begin
        m_flush = 0;
      end else begin
        m_pc = m_pc + 8'd1; m_valid = 1; m_flush = 0;
      end
    end
  endtask

  // One clock: model advances with the edge, outputs are left for sampling at the falling edge.
  task automatic step();
    @(posedge clk);
    #1 model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    clear_inputs();
    model_reset();
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    n_cmp++; if (bus.pc_out !== 8'h00) begin n_bad++; $display("FAIL reset_pc: got %0h want 00", bus.pc_out); end
    n_cmp++; if (bus.pc_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0b want 0", bus.pc_valid); end
    n_cmp++; if (bus.flush !== 1'b0) begin n_bad++; $display("FAIL reset_flush: got %0b want 0", bus.flush); end
    n_cmp++; if (bus.ras_empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty: got %0b want 1", bus.ras_empty); end
    n_cmp++; if (bus.ras_full !== 1'b0) begin n_bad++; $display("FAIL reset_full: got %0b want 0", bus.ras_full); end
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++;
      if (bus.pc_out !== 8'(i) || bus.pc_valid !== 1'b1) begin
        n_bad++; $display("FAIL boot_seq[%0d]: got pc=%0h v=%0b want pc=%0h v=1", i, bus.pc_out, bus.pc_valid, i);
      end
    end
    $display("test_reset done: pc=%0h", bus.pc_out);
  endtask

  task automatic test_stall();
    step(); step();
    n_cmp++; if (bus.pc_out !== 8'h05) begin n_bad++; $display("FAIL stall_start: got %0h want 05", bus.pc_out); end
    bus.stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (bus.pc_out !== 8'h05 || bus.pc_valid !== 1'b1) begin
        n_bad++; $display("FAIL stall_hold[%0d]: got pc=%0h v=%0b want pc=05 v=1", i, bus.pc_out, bus.pc_valid);
      end
    end
    bus.stall = 0;
    step();
    n_cmp++; if (bus.pc_out !== 8'h06) begin n_bad++; $display("FAIL stall_release: got %0h want 06", bus.pc_out); end
    $display("test_stall done: pc=%0h", bus.pc_out);
  endtask

  task automatic test_priority();
    bus.jump = 1; bus.jump_target = 8'h07;
    step();
    clear_inputs();
    step();
    n_cmp++; if (bus.pc_out !== 8'h08 || bus.pc_valid !== 1'b1) begin n_bad++; $display("FAIL prio_setup: got pc=%0h v=%0b want pc=08 v=1", bus.pc_out, bus.pc_valid); end
    bus.branch_taken = 1; bus.branch_target = 8'h40;
    bus.jump = 1; bus.jump_target = 8'h80; bus.stall = 1;
    step();
    clear_inputs();
    n_cmp++; if (bus.pc_out !== 8'h40) begin n_bad++; $display("FAIL prio_pc: got %0h want 40", bus.pc_out); end
    n_cmp++; if (bus.flush !== 1'b1 || bus.pc_valid !== 1'b0) begin n_bad++; $display("FAIL prio_flags: got flush=%0b v=%0b want flush=1 v=0", bus.flush, bus.pc_valid); end
    step();
    n_cmp++; if (bus.pc_out !== 8'h41 || bus.flush !== 1'b0 || bus.pc_valid !== 1'b1) begin
      n_bad++; $display("FAIL prio_after: got pc=%0h f=%0b v=%0b want pc=41 f=0 v=1", bus.pc_out, bus.flush, bus.pc_valid);
    end
    $display("test_priority done: pc=%0h", bus.pc_out);
  endtask

  task automatic test_wrap();
    bus.jump = 1; bus.jump_target = 8'hFE;
    step();
    clear_inputs();
    step();
    n_cmp++; if (bus.pc_out !== 8'hFF) begin n_bad++; $display("FAIL wrap_setup: got %0h want ff", bus.pc_out); end
    n_cmp++; if (bus.pc_plus_out !== 8'h00) begin n_bad++; $display("FAIL wrap_plus_ff: got %0h want 00", bus.pc_plus_out); end
    step();
    n_cmp++; if (bus.pc_out !== 8'h00 || bus.pc_plus_out !== 8'h01) begin
      n_bad++; $display("FAIL wrap_pc: got pc=%0h plus=%0h want pc=00 plus=01", bus.pc_out, bus.pc_plus_out);
    end
    n_cmp++; if (bus.flush !== 1'b0 || bus.pc_valid !== 1'b1) begin n_bad++; $display("FAIL wrap_flags: got f=%0b v=%0b want f=0 v=1", bus.flush, bus.pc_valid); end
    $display("test_wrap done: pc=%0h", bus.pc_out);
  endtask

`ifdef PC_RAS_EN
  task automatic test_ras();
    logic [7:0] exp_ret [5];
    logic [7:0] prev;
    bus.jump = 1; bus.jump_target = 8'h0F;
    step();
    clear_inputs();
    step();
    bus.call = 1; bus.jump = 1; bus.jump_target = 8'h30;
    step();
    clear_inputs();
    n_cmp++; if (bus.ras_empty !== 1'b0) begin n_bad++; $display("FAIL ras_push_empty: got %0b want 0", bus.ras_empty); end
    step(); step();
    bus.ret = 1;
    step();
    clear_inputs();
    n_cmp++; if (bus.pc_out !== 8'h11 || bus.flush !== 1'b1) begin n_bad++; $display("FAIL ras_ret: got pc=%0h f=%0b want pc=11 f=1", bus.pc_out, bus.flush); end
    n_cmp++; if (bus.ras_empty !== 1'b1) begin n_bad++; $display("FAIL ras_ret_empty: got %0b want 1", bus.ras_empty); end
    step();
    for (int k = 0; k < 5; k++) begin
      exp_ret[k] = m_pc + 8'd1;
      bus.call = 1; bus.jump = 1; bus.jump_target = 8'(8'h50 + 16 * k);
      step();
      clear_inputs();
      step();
    end
    n_cmp++; if (bus.ras_full !== 1'b1 || bus.ras_empty !== 1'b0) begin n_bad++; $display("FAIL ras_full: got full=%0b empty=%0b want 1/0", bus.ras_full, bus.ras_empty); end
    for (int k = 0; k < 4; k++) begin
      bus.ret = 1;
      step();
      clear_inputs();
      n_cmp++;
      if (bus.pc_out !== exp_ret[4-k] || bus.flush !== 1'b1) begin
        n_bad++; $display("FAIL ras_pop[%0d]: got pc=%0h f=%0b want pc=%0h f=1", k, bus.pc_out, bus.flush, exp_ret[4-k]);
      end
      step();
    end
    prev = m_pc;
    bus.ret = 1;
    step();
    clear_inputs();
    n_cmp++; if (bus.pc_out !== prev + 8'd1 || bus.flush !== 1'b0 || bus.ras_empty !== 1'b1) begin
      n_bad++; $display("FAIL ras_ret_noop: got pc=%0h f=%0b e=%0b want pc=%0h f=0 e=1", bus.pc_out, bus.flush, bus.ras_empty, prev + 8'd1);
    end
    $display("test_ras done: pc=%0h", bus.pc_out);
  endtask
`endif

  task automatic test_random();
    int bad_before;
    bad_before = n_bad;
    for (int i = 0; i < 400; i++) begin
      bus.stall         = ($urandom_range(3) == 0);
      bus.branch_taken  = ($urandom_range(7) == 0);
      bus.branch_target = 8'($urandom);
      bus.jump          = ($urandom_range(5) == 0);
      bus.jump_target   = 8'($urandom);
      bus.call          = $urandom_range(1);
      bus.ret           = ($urandom_range(4) == 0);
      step();
      n_cmp++;
      if (bus.pc_out !== m_pc || bus.pc_plus_out !== m_pc + 8'd1) begin
        n_bad++; $display("FAIL rand_pc[%0d]: got pc=%0h plus=%0h want pc=%0h plus=%0h", i, bus.pc_out, bus.pc_plus_out, m_pc, m_pc + 8'd1);
      end
      n_cmp++;
      if (bus.pc_valid !== m_valid || bus.flush !== m_flush) begin
        n_bad++; $display("FAIL rand_flags[%0d]: got v=%0b f=%0b want v=%0b f=%0b", i, bus.pc_valid, bus.flush, m_valid, m_flush);
      end
      n_cmp++;
      if (bus.ras_empty !== (m_ras.size() == 0) || bus.ras_full !== (m_ras.size() == 4)) begin
        n_bad++; $display("FAIL rand_ras[%0d]: got e=%0b f=%0b want depth %0d", i, bus.ras_empty, bus.ras_full, m_ras.size());
      end
    end
    clear_inputs();
    $display("test_random done: %0d new mismatches", n_bad - bad_before);
  endtask

  task automatic test_async_reset();
    bus.jump = 1; bus.jump_target = 8'h9A;
    step();
    clear_inputs();
    n_cmp++; if (bus.pc_out !== 8'h9A || bus.flush !== 1'b1) begin n_bad++; $display("FAIL areset_setup: got pc=%0h f=%0b want pc=9a f=1", bus.pc_out, bus.flush); end
    #2 rst_n = 0;
    model_reset();
    #1;
    n_cmp++; if (bus.pc_out !== 8'h00 || bus.flush !== 1'b0) begin n_bad++; $display("FAIL areset_now: got pc=%0h f=%0b want pc=00 f=0", bus.pc_out, bus.flush); end
    n_cmp++; if (bus.pc_valid !== 1'b0 || bus.ras_empty !== 1'b1) begin n_bad++; $display("FAIL areset_state: got v=%0b e=%0b want v=0 e=1", bus.pc_valid, bus.ras_empty); end
    @(negedge clk);
    rst_n = 1;
    step();
    n_cmp++; if (bus.pc_out !== 8'h00 || bus.pc_valid !== 1'b1) begin n_bad++; $display("FAIL areset_boot: got pc=%0h v=%0b want pc=00 v=1", bus.pc_out, bus.pc_valid); end
    step();
    n_cmp++; if (bus.pc_out !== 8'h01) begin n_bad++; $display("FAIL areset_seq: got %0h want 01", bus.pc_out); end
    $display("test_async_reset done: pc=%0h", bus.pc_out);
  endtask

  initial begin
    test_reset();
    test_stall();
    test_priority();
    test_wrap();
`ifdef PC_RAS_EN
    test_ras();
`endif
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
